// File: rtl/transform_loader_pkg.sv
// Shared definitions for the transform table writer/readers: marker bytes,
// loader state encoding and the layout of the 12-bit line-pointer word.
package transform_loader_pkg;

  localparam logic [7:0] DEF_EOL_CHAR = 8'h0A;
  localparam logic [7:0] DEF_EOT_CHAR = 8'h04;
  localparam int         PAIR_DEPTH   = 64;
  localparam int         LINE_DEPTH   = 64;

  // Pointer word = {line_start, line_len}
  localparam int PTR_START_MSB = 11;
  localparam int PTR_START_LSB = 6;
  localparam int PTR_LEN_MSB   = 5;
  localparam int PTR_LEN_LSB   = 0;

  typedef enum logic [2:0] {
    GET_LHS = 3'd0,
    GET_RHS = 3'd1,
    COMMIT  = 3'd2,
    DONE    = 3'd3,
    ERR     = 3'd4
  } state_t;

  function automatic logic [11:0] pack_ptr(input logic [5:0] start, input logic [5:0] len);
    pack_ptr = {start, len};
  endfunction

endpackage

// File: rtl/transform_loader_if.sv
// Byte-stream input plus pair-RAM / pointer-table write ports and status.
interface transform_loader_if;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic        ptr_we;
  logic [5:0]  ptr_line;
  logic [11:0] ptr_wdata;
  logic        done;
  logic        err;
  logic [6:0]  lines_loaded;

  // Loader side
  modport master (
    input  in_valid, in_byte,
    output in_ready, mem_we, mem_waddr, mem_wdata,
    output ptr_we, ptr_line, ptr_wdata, done, err, lines_loaded
  );

  // Stream source / table consumer side
  modport slave (
    output in_valid, in_byte,
    input  in_ready, mem_we, mem_waddr, mem_wdata,
    input  ptr_we, ptr_line, ptr_wdata, done, err, lines_loaded
  );
endinterface

// File: rtl/transform_loader.sv
// Writer side of the transform tables: parses (lhs,rhs) byte pairs grouped
// into lines, writes each pair to the pair RAM and one {start,len} pointer
// word per line to the line-pointer table.
module transform_loader
  import transform_loader_pkg::*;
#(
  parameter logic [7:0] EOL_CHAR = DEF_EOL_CHAR,
  parameter logic [7:0] EOT_CHAR = DEF_EOT_CHAR
) (
  input logic               clk,
  input logic               rst_n,
  transform_loader_if.master bus
);

  state_t      state_q, state_d;
  logic [6:0]  pair_idx;     // 0..64, 64 = RAM full
  logic [6:0]  line_idx;     // 0..64, 64 = table full
  logic [5:0]  line_start;
  logic [5:0]  line_len;
  logic [7:0]  lhs_q;
  logic        eot_q;        // commit in flight was triggered by EOT

  logic        mem_we_q, ptr_we_q;
  logic [7:0]  mem_waddr_q;
  logic [15:0] mem_wdata_q;
  logic [5:0]  ptr_line_q;
  logic [11:0] ptr_wdata_q;

  logic        in_ready, acc;
  logic        lhs_take, rhs_take, eot_commit, commit_go;

  assign in_ready = (state_q == GET_LHS) || (state_q == GET_RHS);
  assign acc      = bus.in_valid && in_ready;

  // Next-state decode and per-cycle action flags
  always_comb begin
    state_d    = state_q;
    lhs_take   = 1'b0;
    rhs_take   = 1'b0;
    eot_commit = 1'b0;
    commit_go  = 1'b0;
    case (state_q)
      GET_LHS: if (acc) begin
        if (bus.in_byte == EOL_CHAR) begin
          state_d = COMMIT;
        end else if (bus.in_byte == EOT_CHAR) begin
          // A trailing partial line still needs its pointer word
          if (line_len != 6'd0) begin
            state_d    = COMMIT;
            eot_commit = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else if (pair_idx == 7'(PAIR_DEPTH) || line_len == 6'd63) begin
          state_d = ERR;
        end else begin
          state_d  = GET_RHS;
          lhs_take = 1'b1;
        end
      end
      GET_RHS: if (acc) begin
        state_d  = GET_LHS;
        rhs_take = 1'b1;
      end
      COMMIT: begin
        if (line_idx == 7'(LINE_DEPTH)) begin
          state_d = ERR;
        end else begin
          commit_go = 1'b1;
          state_d   = eot_q ? DONE : GET_LHS;
        end
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  // State, counters and registered write ports
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= GET_LHS;
      pair_idx    <= '0;
      line_idx    <= '0;
      line_start  <= '0;
      line_len    <= '0;
      lhs_q       <= '0;
      eot_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      ptr_we_q    <= 1'b0;
      ptr_line_q  <= '0;
      ptr_wdata_q <= '0;
    end else begin
      state_q  <= state_d;
      mem_we_q <= rhs_take;
      ptr_we_q <= commit_go;
      if (lhs_take)   lhs_q <= bus.in_byte;
      if (eot_commit) eot_q <= 1'b1;
      if (rhs_take) begin
        mem_waddr_q <= {2'b00, pair_idx[5:0]};
        mem_wdata_q <= {lhs_q, bus.in_byte};
        pair_idx    <= pair_idx + 7'd1;
        line_len    <= line_len + 6'd1;
      end
      if (commit_go) begin
        ptr_line_q  <= line_idx[5:0];
        ptr_wdata_q <= pack_ptr(line_start, line_len);
        line_idx    <= line_idx + 7'd1;
        // pair_idx==64 wraps to 0 here; any further data pair errors out
        line_start  <= pair_idx[5:0];
        line_len    <= '0;
        eot_q       <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_waddr    = mem_waddr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.ptr_we       = ptr_we_q;
  assign bus.ptr_line     = ptr_line_q;
  assign bus.ptr_wdata    = ptr_wdata_q;
  assign bus.done         = (state_q == DONE);
  assign bus.err          = (state_q == ERR);
  assign bus.lines_loaded = line_idx;

endmodule
